// File: rtl/uart_pkg.sv
// Shared serial-subsystem definitions: receiver FSM states and bit-timing shift.
package uart_pkg;
    localparam int PRESCALE_SHIFT = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RST_VAL sets the idle level.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rxd, bytes out on an AXI-Stream master.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);
    localparam int CW = 16 + PRESCALE_SHIFT;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rxd_s;
    rx_state_e             state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [15:0]           ps_q;
    logic [15:0]           ps_eff;
    logic [CW-1:0]         half_cyc;
    logic [CW-1:0]         bit_cyc;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Half period comes from the live prescale (used on leaving IDLE); full
    // bit periods use the value frozen at that moment.
    assign ps_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_cyc = CW'(ps_eff) << (PRESCALE_SHIFT - 1);
    assign bit_cyc  = CW'(ps_q) << PRESCALE_SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            ps_q          <= 16'd1;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        ps_q  <= ps_eff;
                        cnt   <= half_cyc - 1'b1;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rxd_s) begin
                            cnt   <= bit_cyc - 1'b1;
                            idx   <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift[idx] <= rxd_s;
                        cnt        <= bit_cyc - 1'b1;
                        if (idx == IW'(DATA_WIDTH - 1))
                            state <= STOP;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rxd_s) begin
                            // A load in the same cycle as a transfer keeps tvalid high.
                            m_axis_tdata  <= shift;
                            m_axis_tvalid <= 1'b1;
                            overrun_error <= m_axis_tvalid && !m_axis_tready;
                            state         <= IDLE;
                            busy          <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural serial transmitter plus an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;

    int total = 0;
    int bad   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int fe_cnt = 0, ov_cnt = 0, vcyc = 0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
        if (frame_error) fe_cnt++;
        if (overrun_error) ov_cnt++;
        if (m_axis_tvalid) vcyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame at prescale*8 clocks per bit, stretched by skew per-mille; the
    // line is left at the stop level afterwards.
    task automatic send_frame(input logic [7:0] d, input int ps, input int skew, input logic stop);
        real bt;
        bt = ps * 80.0 * (1000.0 + skew) / 1000.0;
        rxd = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bt);
        end
        rxd = stop;
        #(bt);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (rx_q.size() == 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() == 0) chk({tag, " timeout"}, 32'd1, 32'd0);
        else chk(tag, rx_q.pop_front(), exp);
    endtask

    initial begin
        logic [7:0] walk[18];
        logic [7:0] b;
        int f0, o0, v0, ps, skew;

        rst = 1'b0; rxd = 1'b1; m_axis_tready = 1'b1; prescale = 16'd1;
        #1;
        chk("rst tvalid", m_axis_tvalid, 0);
        chk("rst tdata", m_axis_tdata, 0);
        chk("rst busy", busy, 0);
        chk("rst ovr", overrun_error, 0);
        chk("rst fe", frame_error, 0);
        wait_clks(4);
        rst = 1'b1;
        wait_clks(4);

        // Walking-one then thermometer patterns, back-to-back.
        walk[0] = 8'h00;
        for (int i = 0; i < 8; i++) walk[i + 1] = 8'h01 << i;
        for (int i = 0; i < 9; i++) walk[i + 9] = 8'hFF >> (8 - i);
        walk[17] = 8'hFF;
        f0 = fe_cnt; o0 = ov_cnt; v0 = vcyc;
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(walk[i]);
            send_frame(walk[i], 1, 0, 1'b1);
        end
        wait_clks(8);
        chk("walk count", rx_q.size(), 18);
        while (exp_q.size() > 0 && rx_q.size() > 0) chk("walk byte", rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete(); rx_q.delete();
        chk("walk fe", fe_cnt - f0, 0);
        chk("walk ovr", ov_cnt - o0, 0);
        chk("walk vcyc", vcyc - v0, 18);

        // Glitch of two clocks.
        f0 = fe_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        wait_clks(2);
        rxd = 1'b1;
        wait_clks(12);
        chk("glitch busy", busy, 0);
        chk("glitch fe", fe_cnt - f0, 0);
        chk("glitch tvalid", rx_q.size(), 0);

        // Stop bit low: error, then held until the line goes high.
        f0 = fe_cnt;
        send_frame(8'h55, 1, 0, 1'b0);
        wait_clks(40);
        chk("frame fe", fe_cnt - f0, 1);
        chk("frame hold busy", busy, 1);
        chk("frame no byte", rx_q.size(), 0);
        rxd = 1'b1;
        wait_clks(10);
        chk("frame release busy", busy, 0);
        send_frame(8'hA5, 1, 0, 1'b1);
        expect_byte("after frame err", 8'hA5);

        // Overrun with tready low.
        o0 = ov_cnt;
        @(posedge clk); #1 m_axis_tready = 1'b0;
        send_frame(8'h11, 1, 0, 1'b1);
        send_frame(8'h22, 1, 0, 1'b1);
        wait_clks(10);
        chk("ovr pulse", ov_cnt - o0, 1);
        chk("ovr tvalid", m_axis_tvalid, 1);
        chk("ovr tdata", m_axis_tdata, 8'h22);
        chk("ovr no xfer", rx_q.size(), 0);
        @(posedge clk); #1 m_axis_tready = 1'b1;
        wait_clks(4);
        chk("ovr one xfer", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("ovr xfer data", rx_q.pop_front(), 8'h22);
        chk("ovr tvalid clr", m_axis_tvalid, 0);

        // Reset in the middle of data bit 4, held until the frame has ended.
        fork
            send_frame(8'h3C, 1, 0, 1'b1);
            begin
                #(80.0 * 5.5);
                rst = 1'b0;
                #1;
                chk("midrst tvalid", m_axis_tvalid, 0);
                chk("midrst busy", busy, 0);
                chk("midrst tdata", m_axis_tdata, 0);
            end
        join
        wait_clks(4);
        rst = 1'b1;
        wait_clks(8);
        chk("midrst no byte", rx_q.size(), 0);
        send_frame(8'hC3, 1, 0, 1'b1);
        expect_byte("after midrst", 8'hC3);

        // prescale=4 with transmitter 3% slow and 3% fast.
        prescale = 16'd4;
        send_frame(8'hC3, 4, 30, 1'b1);
        expect_byte("slow C3", 8'hC3);
        send_frame(8'h5A, 4, 30, 1'b1);
        expect_byte("slow 5A", 8'h5A);
        send_frame(8'hC3, 4, -30, 1'b1);
        expect_byte("fast C3", 8'hC3);
        send_frame(8'h5A, 4, -30, 1'b1);
        expect_byte("fast 5A", 8'h5A);

        // Random bytes, prescale and skew within +/-3%.
        f0 = fe_cnt; o0 = ov_cnt;
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            ps   = $urandom_range(4, 1);
            skew = int'($urandom_range(60, 0)) - 30;
            prescale = 16'(ps);
            send_frame(b, ps, skew, 1'b1);
            expect_byte("rand byte", b);
            if ($urandom_range(1, 0) == 1) wait_clks($urandom_range(20, 1));
        end
        chk("rand fe", fe_cnt - f0, 0);
        chk("rand ovr", ov_cnt - o0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
